write_sector_decoder: RTL and testbench

Parametrised serial write-stream decoder for the disk emulator. It sits after the data separator and consumes one recovered bit per wr_clock.
- Finds the preamble and sync bit, optionally parses and checks the sector header, then deframes the data field into bytes on a parallel bus.
- Adds the following over the fixed-format decoder: a write-gate abort, preamble length qualification, header check compare, byte indexing and an end-of-sector pulse.

---
 rtl/wd_pkg.sv | 17 +
 rtl/sync_detector.sv | 39 +++
 rtl/write_sector_decoder.sv | 188 ++++++++++++++++++
 tb/tb_write_sector_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// Shared types and default geometry for the write-stream sector decoder.
package wd_pkg;

    localparam int unsigned HAWK_DATA_BYTES   = 403;
    localparam int unsigned HAWK_ADDR_BITS    = 16;
    localparam int unsigned HAWK_MIN_PREAMBLE = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE1,
        S_ADDR,
        S_CHECK,
        S_PRE2,
        S_DATA
    } state_e;

endpackage

// File: rtl/sync_detector.sv
// Preamble qualifier: counts consecutive zero bits and flags a sync 1 that
// follows a run of at least MIN_PREAMBLE zeros.
module sync_detector
    import wd_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE = HAWK_MIN_PREAMBLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic bit_i,
    output logic sync_c
);

    localparam int unsigned ZC_W = $clog2(MIN_PREAMBLE + 1);

    logic [ZC_W-1:0] zc_q, zc_d;
    logic            run_ok_c;

    assign run_ok_c = (zc_q >= ZC_W'(MIN_PREAMBLE));
    assign sync_c   = en_i && bit_i && run_ok_c;

    // Zero-run counter saturates; any 1 or leaving the preamble restarts it.
    always_comb begin
        zc_d = '0;
        if (en_i && !bit_i) begin
            zc_d = run_ok_c ? zc_q : zc_q + ZC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zc_q <= '0;
        end else begin
            zc_q <= zc_d;
        end
    end

endmodule

// File: rtl/write_sector_decoder.sv
// Serial write-stream decoder: preamble/sync search, optional header parse
// and check, then data-field deframing into indexed bytes.
module write_sector_decoder
    import wd_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = HAWK_ADDR_BITS,
    parameter int unsigned DATA_BYTES   = HAWK_DATA_BYTES,
    parameter int unsigned MIN_PREAMBLE = HAWK_MIN_PREAMBLE,
    parameter int unsigned IDX_W        = $clog2(DATA_BYTES)
) (
    input  logic                 wr_clock,
    input  logic                 reset_n,
    input  logic                 wr_gate,
    input  logic                 need_address,
    input  logic [ADDR_BITS-1:0] saddr_in,
    input  logic                 wr_data,
    output logic [ADDR_BITS-1:0] saddr_out,
    output logic [7:0]           data,
    output logic                 data_available,
    output logic [IDX_W-1:0]     byte_index,
    output logic                 hdr_err,
    output logic                 sector_done,
    output logic                 busy
);

    localparam int unsigned AB_W = $clog2(ADDR_BITS);

    state_e               state_q, state_d;
    logic [ADDR_BITS-2:0] addr_sh_q, addr_sh_d;
    logic [AB_W-1:0]      ab_q, ab_d;
    logic [6:0]           data_sh_q, data_sh_d;
    logic [2:0]           bc_q, bc_d;
    logic [IDX_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [ADDR_BITS-1:0] saddr_q, saddr_d;
    logic [7:0]           data_q, data_d;
    logic                 avail_q, avail_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 hdr_err_q, hdr_err_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 in_pre_c;
    logic                 sync_c;
    logic [ADDR_BITS-1:0] word_c;
    logic [7:0]           byte_c;

    assign in_pre_c = (state_q == S_PRE1) || (state_q == S_PRE2);
    assign word_c   = {addr_sh_q, wr_data};
    assign byte_c   = {data_sh_q, wr_data};

    sync_detector #(
        .MIN_PREAMBLE(MIN_PREAMBLE)
    ) u_sync (
        .clk   (wr_clock),
        .rst_n (reset_n),
        .en_i  (in_pre_c),
        .bit_i (wr_data),
        .sync_c(sync_c)
    );

    always_comb begin
        state_d    = state_q;
        addr_sh_d  = addr_sh_q;
        ab_d       = ab_q;
        data_sh_d  = data_sh_q;
        bc_d       = bc_q;
        byte_cnt_d = byte_cnt_q;
        saddr_d    = saddr_q;
        data_d     = data_q;
        avail_d    = 1'b0;
        idx_d      = idx_q;
        hdr_err_d  = hdr_err_q;
        done_d     = 1'b0;

        // Write-gate drop aborts from anywhere; partial byte is discarded.
        if (state_q != S_IDLE && !wr_gate) begin
            state_d    = S_IDLE;
            ab_d       = '0;
            bc_d       = '0;
            byte_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ab_d       = '0;
                    bc_d       = '0;
                    byte_cnt_d = '0;
                    if (wr_gate) begin
                        hdr_err_d = 1'b0;
                        if (need_address) begin
                            state_d = S_PRE1;
                        end else begin
                            state_d = S_PRE2;
                            saddr_d = saddr_in;
                        end
                    end
                end
                S_PRE1: begin
                    if (sync_c) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_sh_d = word_c[ADDR_BITS-2:0];
                    ab_d      = ab_q + AB_W'(1);
                    if (ab_q == AB_W'(ADDR_BITS - 1)) begin
                        saddr_d = word_c;
                        ab_d    = '0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    addr_sh_d = word_c[ADDR_BITS-2:0];
                    ab_d      = ab_q + AB_W'(1);
                    if (ab_q == AB_W'(ADDR_BITS - 1)) begin
                        hdr_err_d = (word_c != saddr_q);
                        ab_d      = '0;
                        state_d   = S_PRE2;
                    end
                end
                S_PRE2: begin
                    if (sync_c) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    data_sh_d = byte_c[6:0];
                    bc_d      = bc_q + 3'd1;
                    if (bc_q == 3'd7) begin
                        data_d     = byte_c;
                        avail_d    = 1'b1;
                        idx_d      = byte_cnt_q;
                        byte_cnt_d = byte_cnt_q + IDX_W'(1);
                        if (byte_cnt_q == IDX_W'(DATA_BYTES - 1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wr_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_sh_q  <= '0;
            ab_q       <= '0;
            data_sh_q  <= '0;
            bc_q       <= '0;
            byte_cnt_q <= '0;
            saddr_q    <= '0;
            data_q     <= '0;
            avail_q    <= 1'b0;
            idx_q      <= '0;
            hdr_err_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_sh_q  <= addr_sh_d;
            ab_q       <= ab_d;
            data_sh_q  <= data_sh_d;
            bc_q       <= bc_d;
            byte_cnt_q <= byte_cnt_d;
            saddr_q    <= saddr_d;
            data_q     <= data_d;
            avail_q    <= avail_d;
            idx_q      <= idx_d;
            hdr_err_q  <= hdr_err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign saddr_out      = saddr_q;
    assign data           = data_q;
    assign data_available = avail_q;
    assign byte_index     = idx_q;
    assign hdr_err        = hdr_err_q;
    assign sector_done    = done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_write_sector_decoder.sv
// Scoreboarded bench for write_sector_decoder: sector streams are generated
// from the framing rules and expected bytes queued for an independent monitor.
module tb_write_sector_decoder;

    localparam int unsigned ADDR_BITS  = 16;
    localparam int unsigned DATA_BYTES = 403;
    localparam int unsigned MIN_PRE    = 16;
    localparam int unsigned IDX_W      = $clog2(DATA_BYTES);

    logic                 wr_clock = 1'b0;
    logic                 reset_n;
    logic                 wr_gate;
    logic                 need_address;
    logic [ADDR_BITS-1:0] saddr_in;
    logic                 wr_data;
    logic [ADDR_BITS-1:0] saddr_out;
    logic [7:0]           data;
    logic                 data_available;
    logic [IDX_W-1:0]     byte_index;
    logic                 hdr_err;
    logic                 sector_done;
    logic                 busy;

    write_sector_decoder #(
        .ADDR_BITS   (ADDR_BITS),
        .DATA_BYTES  (DATA_BYTES),
        .MIN_PREAMBLE(MIN_PRE),
        .IDX_W       (IDX_W)
    ) dut (
        .wr_clock      (wr_clock),
        .reset_n       (reset_n),
        .wr_gate       (wr_gate),
        .need_address  (need_address),
        .saddr_in      (saddr_in),
        .wr_data       (wr_data),
        .saddr_out     (saddr_out),
        .data          (data),
        .data_available(data_available),
        .byte_index    (byte_index),
        .hdr_err       (hdr_err),
        .sector_done   (sector_done),
        .busy          (busy)
    );

    always #5 wr_clock = ~wr_clock;

    typedef struct packed {
        logic [7:0]           data;
        logic [IDX_W-1:0]     idx;
        logic                 done;
        logic [ADDR_BITS-1:0] saddr;
        logic                 hdr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   scramble = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One bit time; need_address/saddr_in wander mid-sector and must be ignored.
    task automatic cycle(input logic g, input logic d);
        wr_gate = g;
        wr_data = d;
        if (scramble) begin
            need_address = 1'($urandom);
            saddr_in     = ADDR_BITS'($urandom);
        end
        @(posedge wr_clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_saddr"}, 32'(saddr_out), 32'd0);
        check({tag, "_data"},  32'(data), 32'd0);
        check({tag, "_avail"}, 32'(data_available), 32'd0);
        check({tag, "_idx"},   32'(byte_index), 32'd0);
        check({tag, "_hdr"},   32'(hdr_err), 32'd0);
        check({tag, "_done"},  32'(sector_done), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // dmode: 0 = index mod 256, 1 = random, 2 = 0xA5 + index.
    // ab_kind: 0 = none, 1 = gate drop, 2 = async reset, at (ab_byte, ab_bit).
    task automatic run_sector(input bit need, input logic [ADDR_BITS-1:0] addr,
                              input logic [ADDR_BITS-1:0] chk, input int pre1,
                              input int pre2, input int short_len, input int dmode,
                              input int ab_byte, input int ab_bit, input int ab_kind);
        logic       exp_hdr;
        logic [7:0] b;
        exp_hdr      = need ? (addr != chk) : 1'b0;
        scramble     = 1'b0;
        need_address = need;
        saddr_in     = need ? ADDR_BITS'($urandom) : addr;
        cycle(1'b1, 1'($urandom));
        check("start_busy", 32'(busy), 32'd1);
        check("start_hdr_clear", 32'(hdr_err), 32'd0);
        if (!need) check("start_saddr", 32'(saddr_out), 32'(addr));
        scramble = 1'b1;
        if (short_len > 0) begin
            repeat (short_len) cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b1);
        end
        if (need) begin
            repeat (pre1) cycle(1'b1, 1'b0);
            cycle(1'b1, 1'b1);
            for (int i = int'(ADDR_BITS) - 1; i >= 0; i--) cycle(1'b1, addr[i]);
            for (int i = int'(ADDR_BITS) - 1; i >= 0; i--) cycle(1'b1, chk[i]);
            check("hdr_saddr", 32'(saddr_out), 32'(addr));
            check("hdr_err_after_check", 32'(hdr_err), 32'(exp_hdr));
        end
        repeat (pre2) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            case (dmode)
                0:       b = 8'(i);
                1:       b = 8'($urandom);
                default: b = 8'(8'hA5 + i);
            endcase
            for (int k = 0; k < 8; k++) begin
                if (ab_kind != 0 && i == ab_byte && k == ab_bit) begin
                    if (ab_kind == 1) begin
                        cycle(1'b0, 1'($urandom));
                        check("abort_busy", 32'(busy), 32'd0);
                        check("abort_saddr_kept", 32'(saddr_out), 32'(addr));
                        check("abort_hdr_kept", 32'(hdr_err), 32'(exp_hdr));
                    end else begin
                        #2 reset_n = 1'b0;
                        #1 check_reset_values("async_reset");
                        @(posedge wr_clock);
                        #1 reset_n = 1'b1;
                    end
                    return;
                end
                if (k == 7) begin
                    exp_q.push_back('{data: b, idx: IDX_W'(i),
                                      done: (i == int'(DATA_BYTES) - 1),
                                      saddr: addr, hdr: exp_hdr});
                end
                cycle(1'b1, b[7-k]);
            end
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge wr_clock) begin
        exp_t e;
        if (reset_n) begin
            if (data_available) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(data_available), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 32'(data), 32'(e.data));
                    check("byte_index", 32'(byte_index), 32'(e.idx));
                    check("sector_done", 32'(sector_done), 32'(e.done));
                    check("strobe_saddr", 32'(saddr_out), 32'(e.saddr));
                    check("strobe_hdr_err", 32'(hdr_err), 32'(e.hdr));
                    check("strobe_busy", 32'(busy), 32'(!e.done));
                end
            end else begin
                check("stray_sector_done", 32'(sector_done), 32'd0);
            end
        end
    end

    initial begin
        logic [ADDR_BITS-1:0] a, c;
        reset_n      = 1'b0;
        wr_gate      = 1'b0;
        wr_data      = 1'b0;
        need_address = 1'b0;
        saddr_in     = '0;
        repeat (3) @(posedge wr_clock);
        #1 check_reset_values("reset");
        reset_n = 1'b1;
        idle(2);
        check("idle_gate_low_busy", 32'(busy), 32'd0);

        // Format path, matching header.
        run_sector(1'b1, 16'h1234, 16'h1234, 20, 20, 0, 0, 0, 0, 0);
        idle(3);
        // Header mismatch still decodes data.
        run_sector(1'b1, 16'h1234, 16'h1235, 20, 20, 0, 0, 0, 0, 0);
        idle(3);
        // Short preamble rejected, then exactly MIN_PRE zeros accepted.
        run_sector(1'b0, 16'h00AB, 16'h0000, 0, MIN_PRE, 10, 2, 1, 0, 1);
        idle(2);
        // Abort at byte 100 bit 3, then immediate restart.
        a = ADDR_BITS'($urandom);
        run_sector(1'b1, a, a, 20, 20, 0, 1, 100, 3, 1);
        run_sector(1'b0, ADDR_BITS'($urandom), 16'h0000, 0, 18, 0, 1, 0, 0, 0);
        // Back-to-back with gate held high.
        run_sector(1'b0, ADDR_BITS'($urandom), 16'h0000, 0, 17, 0, 1, 0, 0, 0);
        a = ADDR_BITS'($urandom);
        run_sector(1'b1, a, a, MIN_PRE, MIN_PRE, 0, 1, 0, 0, 0);
        idle(2);
        // Asynchronous reset mid-data.
        run_sector(1'b0, ADDR_BITS'($urandom), 16'h0000, 0, 18, 0, 1, 50, 3, 2);
        idle(2);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Randomised sectors.
        for (int s = 0; s < 4; s++) begin
            a = ADDR_BITS'($urandom);
            c = ($urandom_range(0, 1) == 0) ? a : (a ^ ADDR_BITS'(1 << $urandom_range(0, ADDR_BITS - 1)));
            run_sector(1'($urandom), a, c,
                       int'(MIN_PRE) + int'($urandom_range(0, 6)),
                       int'(MIN_PRE) + int'($urandom_range(0, 6)),
                       ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, MIN_PRE - 1)),
                       1,
                       int'($urandom_range(0, DATA_BYTES - 1)),
                       int'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? 1 : 0);
            idle(int'($urandom_range(0, 3)));
        end

        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
